digit_accumulator: RTL and testbench
====================================

DIGIT_ACCUMULATOR -- requirements
Module: digit_accumulator

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, digits per entry (legal range 1..8).
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: digit_in  input  4  binary digit from the ASCII-to-binary stage; 0..9 legal.
REQ-005 Port: digit_valid  input  1  one-cycle strobe qualifying digit_in.
REQ-006 Port: entry_start  input  1  one-cycle strobe arming a new entry (account number or PIN).
REQ-007 Port: key_back  input  1  one-cycle strobe: delete last digit.
REQ-008 Port: key_enter  input  1  one-cycle strobe: submit entry.
REQ-009 Port: key_quit  input  1  one-cycle strobe: abort entry ('q').
REQ-010 Port: bcd_value  output  4*NUM_DIGITS  packed BCD entry; most recent digit in bits [3:0].
REQ-011 Port: count  output  4  number of digits currently held.
REQ-012 Port: active  output  1  high in COLLECT or FULL.
REQ-013 Port: entry_done  output  1  one-cycle pulse: complete entry submitted.
REQ-014 Port: entry_error  output  1  one-cycle pulse: rejected input.
REQ-015 Port: entry_abort  output  1  one-cycle pulse: entry aborted by key_quit.

Function
REQ-016 FSM states: IDLE, COLLECT, FULL, DONE; all outputs registered, updating on the edge after the triggering strobe.
REQ-017 Strobe priority within one cycle: key_quit > key_back > key_enter > digit_valid; lower-priority strobes in that cycle are ignored; entry_start is honoured only in IDLE and DONE.
REQ-018 IDLE: entry_start -> COLLECT, count=0, bcd_value=0; all other strobes ignored, bcd_value holds last value.
REQ-019 COLLECT, digit_valid with digit_in<=9: bcd_value shifts left 4 bits, digit_in enters bits [3:0], count+1; if new count==NUM_DIGITS -> FULL.
REQ-020 COLLECT or FULL, digit_valid with digit_in>9: entry_error pulse, bcd_value/count unchanged, state unchanged.
REQ-021 FULL, digit_valid (any value): entry_error pulse, no data change (overflow rejected).
REQ-022 key_back in COLLECT with count>0, or in FULL: bcd_value shifts right 4 bits (zero fill at top), count-1, state -> COLLECT; key_back with count==0 ignored, no error.
REQ-023 key_enter in COLLECT (count<NUM_DIGITS): entry_error pulse, no other change.
REQ-024 key_enter in FULL: -> DONE, entry_done pulse in the same registered update; bcd_value and count held.
REQ-025 DONE lasts exactly one cycle, then -> IDLE, bcd_value and count held until next entry_start.
REQ-026 key_quit in COLLECT or FULL: -> IDLE, count=0, bcd_value=0, entry_abort pulse; key_quit in IDLE/DONE ignored.
REQ-027 entry_done, entry_error, entry_abort mutually exclusive and never high for two consecutive cycles from one strobe.
REQ-028 active = 1 exactly when state is COLLECT or FULL.
REQ-029 count never exceeds NUM_DIGITS and never wraps below 0.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, bcd_value 0, count 0, active 0, entry_done 0, entry_error 0, entry_abort 0.
REQ-031 Reset mid-entry discards partial entry; first cycle after rst_n release ignores all strobes except entry_start.
REQ-032 Reset deassertion requires no strobes in the same cycle; block behaves from the next rising edge.

Verification
REQ-033 entry_start, digits 1,2,3,4, key_enter -> bcd_value=16'h1234, count=4, entry_done one pulse, then IDLE holding 16'h1234.
REQ-034 entry_start, digits 5,6,7, key_enter -> entry_error pulse, count=3, bcd_value=16'h0567, state COLLECT.
REQ-035 entry_start, digits 9,8,7,6, digit 5 -> entry_error pulse, bcd_value stays 16'h9876; key_back -> 16'h0987, count=3, active=1.
REQ-036 entry_start, digit_in=4'hA strobed -> entry_error pulse, count=0; key_back at count 0 -> no change, no error.
REQ-037 entry_start, digits 1,2, key_quit together with digit_valid -> entry_abort pulse, bcd_value=0, count=0, active=0.
REQ-038 entry_start, digits 3,1, rst_n low mid-cycle -> outputs zero immediately, before the next clk edge.

Source files
------------

// File: rtl/digit_accumulator.sv
// Collects decimal key digits into a packed BCD entry (account number or PIN)
// with backspace, submit and abort handling for the terminal keypad path.
module digit_accumulator #(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              digit_in,
   input  logic                    digit_valid,
   input  logic                    entry_start,
   input  logic                    key_back,
   input  logic                    key_enter,
   input  logic                    key_quit,
   output logic [4*NUM_DIGITS-1:0] bcd_value,
   output logic [3:0]              count,
   output logic                    active,
   output logic                    entry_done,
   output logic                    entry_error,
   output logic                    entry_abort
);

   localparam int         W         = 4 * NUM_DIGITS;
   localparam logic [3:0] MAX_COUNT = 4'(NUM_DIGITS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t state;

   // Entry FSM with all outputs registered; strobe priority is quit > back > enter > digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bcd_value   <= '0;
         count       <= 4'd0;
         active      <= 1'b0;
         entry_done  <= 1'b0;
         entry_error <= 1'b0;
         entry_abort <= 1'b0;
      end else begin
         entry_done  <= 1'b0;
         entry_error <= 1'b0;
         entry_abort <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (entry_start) begin
                  state     <= COLLECT;
                  bcd_value <= '0;
                  count     <= 4'd0;
                  active    <= 1'b1;
               end else begin
                  state  <= IDLE;
                  active <= 1'b0;
               end
            end
            COLLECT, FULL: begin
               if (key_quit) begin
                  state       <= IDLE;
                  bcd_value   <= '0;
                  count       <= 4'd0;
                  active      <= 1'b0;
                  entry_abort <= 1'b1;
               end else if (key_back) begin
                  // FULL implies count > 0, so only an empty COLLECT ignores backspace
                  if (state == FULL || count != 4'd0) begin
                     bcd_value <= bcd_value >> 3'd4;
                     count     <= count - 4'd1;
                     state     <= COLLECT;
                  end else begin
                     state <= state;
                  end
               end else if (key_enter) begin
                  if (state == FULL) begin
                     state      <= DONE;
                     active     <= 1'b0;
                     entry_done <= 1'b1;
                  end else begin
                     entry_error <= 1'b1;
                  end
               end else if (digit_valid) begin
                  if (state == FULL || digit_in > 4'd9) begin
                     entry_error <= 1'b1;
                  end else begin
                     bcd_value <= (bcd_value << 3'd4) | W'(digit_in);
                     count     <= count + 4'd1;
                     if (count + 4'd1 == MAX_COUNT) begin
                        state <= FULL;
                     end else begin
                        state <= COLLECT;
                     end
                  end
               end else begin
                  state <= state;
               end
            end
            default: begin
               state     <= IDLE;
               bcd_value <= '0;
               count     <= 4'd0;
               active    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_accumulator.sv
// Checks digit_accumulator against a digit-list model: directed entry scenarios
// with literal expectations, then randomized keypad traffic and occasional resets.
module tb_digit_accumulator;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [3:0]     digit_in = 4'd0;
   logic           digit_valid = 1'b0;
   logic           entry_start = 1'b0;
   logic           key_back = 1'b0;
   logic           key_enter = 1'b0;
   logic           key_quit = 1'b0;
   logic [4*N-1:0] bcd_value;
   logic [3:0]     count;
   logic           active;
   logic           entry_done;
   logic           entry_error;
   logic           entry_abort;

   digit_accumulator #(.NUM_DIGITS(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .entry_start (entry_start),
      .key_back    (key_back),
      .key_enter   (key_enter),
      .key_quit    (key_quit),
      .bcd_value   (bcd_value),
      .count       (count),
      .active      (active),
      .entry_done  (entry_done),
      .entry_error (entry_error),
      .entry_abort (entry_abort)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: the digits typed so far, oldest first, plus a phase 0=idle 1=entering 2=done.
   int   digits[$];
   int   mode = 0;
   logic e_done = 1'b0, e_err = 1'b0, e_abt = 1'b0;

   function automatic logic [4*N-1:0] model_bcd();
      logic [4*N-1:0] v;
      v = '0;
      foreach (digits[i]) v = (v << 4) | (4*N)'(digits[i]);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("bcd_value", 32'(bcd_value), 32'(model_bcd()));
      check("count", 32'(count), digits.size());
      check("active", 32'(active), 32'(mode == 1));
      check("entry_done", 32'(entry_done), 32'(e_done));
      check("entry_error", 32'(entry_error), 32'(e_err));
      check("entry_abort", 32'(entry_abort), 32'(e_abt));
   endtask

   task automatic step(input logic st, input logic dv, input logic [3:0] d,
                       input logic kb, input logic ke, input logic kq);
      entry_start = st; digit_valid = dv; digit_in = d;
      key_back = kb; key_enter = ke; key_quit = kq;
      e_done = 1'b0; e_err = 1'b0; e_abt = 1'b0;
      if (mode == 1) begin
         if (kq) begin
            digits.delete(); mode = 0; e_abt = 1'b1;
         end else if (kb) begin
            if (digits.size() > 0) void'(digits.pop_back());
         end else if (ke) begin
            if (digits.size() == N) begin mode = 2; e_done = 1'b1; end
            else e_err = 1'b1;
         end else if (dv) begin
            if (d > 4'd9 || digits.size() == N) e_err = 1'b1;
            else digits.push_back(int'(d));
         end
      end else if (st) begin
         digits.delete(); mode = 1;
      end else begin
         mode = 0;
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle();            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
   task automatic start();           step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
   task automatic dig(input logic [3:0] d); step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0); endtask
   task automatic back();            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
   task automatic enter();           step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
   task automatic quit();            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask

   task automatic do_reset();
      entry_start = 1'b0; digit_valid = 1'b0; key_back = 1'b0;
      key_enter = 1'b0; key_quit = 1'b0; digit_in = 4'd0;
      rst_n = 1'b0;
      digits.delete(); mode = 0; e_done = 1'b0; e_err = 1'b0; e_abt = 1'b0;
      #1;
      compare_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic st, dv, kb, ke, kq;
      logic [3:0] d;

      do_reset();

      // Complete four-digit entry and submit.
      start(); dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
      check("pin_1234_bcd", 32'(bcd_value), 32'h1234);
      check("pin_1234_count", 32'(count), 32'd4);
      check("model_pin_1234", 32'(model_bcd()), 32'h1234);
      enter();
      check("pin_1234_done", 32'(entry_done), 32'd1);
      idle();
      check("pin_1234_done_once", 32'(entry_done), 32'd0);
      check("pin_1234_held", 32'(bcd_value), 32'h1234);
      check("pin_1234_inactive", 32'(active), 32'd0);
      idle(); idle();

      // Premature enter.
      start(); dig(4'd5); dig(4'd6); dig(4'd7); enter();
      check("short_enter_err", 32'(entry_error), 32'd1);
      check("short_enter_bcd", 32'(bcd_value), 32'h0567);
      check("short_enter_count", 32'(count), 32'd3);
      check("short_enter_active", 32'(active), 32'd1);
      quit();

      // Overflow then backspace out of FULL.
      start(); dig(4'd9); dig(4'd8); dig(4'd7); dig(4'd6); dig(4'd5);
      check("overflow_err", 32'(entry_error), 32'd1);
      check("overflow_bcd", 32'(bcd_value), 32'h9876);
      back();
      check("back_full_bcd", 32'(bcd_value), 32'h0987);
      check("back_full_count", 32'(count), 32'd3);
      check("back_full_active", 32'(active), 32'd1);
      quit();

      // Illegal digit, then backspace on an empty entry.
      start(); dig(4'hA);
      check("bad_digit_err", 32'(entry_error), 32'd1);
      check("bad_digit_count", 32'(count), 32'd0);
      back();
      check("empty_back_err", 32'(entry_error), 32'd0);
      check("empty_back_count", 32'(count), 32'd0);
      quit();

      // Quit wins over a simultaneous digit.
      start(); dig(4'd1); dig(4'd2);
      step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
      check("quit_abort", 32'(entry_abort), 32'd1);
      check("quit_bcd", 32'(bcd_value), 32'h0);
      check("quit_count", 32'(count), 32'd0);
      check("quit_active", 32'(active), 32'd0);

      // Asynchronous reset mid-entry, between clock edges.
      start(); dig(4'd3); dig(4'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_bcd", 32'(bcd_value), 32'h0);
      check("async_rst_count", 32'(count), 32'd0);
      check("async_rst_active", 32'(active), 32'd0);
      do_reset();

      // Randomized keypad traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            st = ($urandom_range(0, 99) < 12);
            kq = ($urandom_range(0, 99) < 4);
            kb = ($urandom_range(0, 99) < 12);
            ke = ($urandom_range(0, 99) < 12);
            dv = ($urandom_range(0, 99) < 55);
            d  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 9));
            step(st, dv, d, kb, ke, kq);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
